// File: rtl/maze_bitmap_store_pkg.sv
// Shared constants and types for the maze bitmap store.
// Holds the default maze geometry, the idle row code and the bus payload types
// used by the top and the pixel lookup pipeline.
package maze_pkg;

    localparam int unsigned ROWS_DEF       = 31;
    localparam int unsigned COLS_DEF       = 28;
    localparam int unsigned TILE_SHIFT_DEF = 3;
    localparam int unsigned X_OFFSET_DEF   = 208;
    localparam int unsigned Y_OFFSET_DEF   = 116;
    localparam int unsigned IDLE_ROW       = 31;

    localparam int unsigned PIX_W = 12;
    localparam int unsigned ROW_W = 32;
    localparam int unsigned IDX_W = 5;

    typedef logic [ROW_W-1:0] row_t;
    typedef logic [IDX_W-1:0] row_idx_t;

endpackage

// File: rtl/maze_pixel_lookup.sv
// Two-stage pixel-to-tile lookup.
// Stage 1 turns (pix_x, pix_y) into a tile row/column plus an inside-maze flag;
// stage 2 reads the selected bit of the active row and registers wall_o.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   pix_x_i, pix_y_i  pixel coordinates
//   pix_de_i          data enable for the coordinates
//   row_sel_o         stage-1 tile row; the owner of the bitmap returns that row
//   row_vec_i         active bitmap row selected by row_sel_o
//   wall_o            pixel is a wall tile, two cycles after pix_*
module maze_pixel_lookup
    import maze_pkg::*;
#(
    parameter int unsigned ROWS       = ROWS_DEF,
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int unsigned X_OFFSET   = X_OFFSET_DEF,
    parameter int unsigned Y_OFFSET   = Y_OFFSET_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PIX_W-1:0] pix_x_i,
    input  logic [PIX_W-1:0] pix_y_i,
    input  logic             pix_de_i,
    output row_idx_t         row_sel_o,
    input  logic [COLS-1:0]  row_vec_i,
    output logic             wall_o
);

    localparam int unsigned MAZE_W = COLS << TILE_SHIFT;
    localparam int unsigned MAZE_H = ROWS << TILE_SHIFT;

    logic [PIX_W-1:0] dx_c;
    logic [PIX_W-1:0] dy_c;
    logic             inside_c;
    row_idx_t         col_c;
    row_idx_t         row_c;

    logic     de_q;
    logic     inside_q;
    row_idx_t col_q;
    row_idx_t row_q;
    logic     wall_q;

    // Unsigned wrap-around makes pixels left of / above the maze look far outside.
    assign dx_c     = pix_x_i - PIX_W'(X_OFFSET);
    assign dy_c     = pix_y_i - PIX_W'(Y_OFFSET);
    assign inside_c = (dx_c < PIX_W'(MAZE_W)) && (dy_c < PIX_W'(MAZE_H));
    assign col_c    = IDX_W'(dx_c >> TILE_SHIFT);
    assign row_c    = IDX_W'(dy_c >> TILE_SHIFT);

    // Stage 1: coordinate to tile.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            de_q     <= 1'b0;
            inside_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            de_q     <= pix_de_i;
            inside_q <= inside_c;
            col_q    <= col_c;
            row_q    <= row_c;
        end
    end

    // Stage 2: bit select from the active row; col_q only matters when inside_q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wall_q <= 1'b0;
        end else begin
            wall_q <= de_q & inside_q & row_vec_i[col_q];
        end
    end

    assign row_sel_o = row_q;
    assign wall_o    = wall_q;

endmodule

// File: rtl/maze_bitmap_store.sv
// Maze bitmap store: captures software row writes into a shadow bitmap,
// commits the shadow to the active bitmap at frame start, and serves
// per-pixel wall lookups from the active bitmap.
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   bg_data              row bitmap, bit c = wall at column c
//   bg_wr                row index, IDLE_ROW when no write is pending
//   frame_start          one-cycle pulse at start of vertical blanking
//   pix_x, pix_y, pix_de pixel stream coordinates and enable
//   wall                 pixel is a wall tile (2-cycle latency)
//   refresh_image        1 once a frame start has passed with no newer write
//   dirty                shadow holds uncommitted writes
module maze_bitmap_store
    import maze_pkg::*;
#(
    parameter int unsigned ROWS       = ROWS_DEF,
    parameter int unsigned COLS       = COLS_DEF,
    parameter int unsigned TILE_SHIFT = TILE_SHIFT_DEF,
    parameter int unsigned X_OFFSET   = X_OFFSET_DEF,
    parameter int unsigned Y_OFFSET   = Y_OFFSET_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  row_t             bg_data,
    input  row_idx_t         bg_wr,
    input  logic             frame_start,
    input  logic [PIX_W-1:0] pix_x,
    input  logic [PIX_W-1:0] pix_y,
    input  logic             pix_de,
    output logic             wall,
    output logic             refresh_image,
    output logic             dirty
);

    logic [COLS-1:0] shadow_q [ROWS];
    logic [COLS-1:0] active_q [ROWS];

    row_idx_t bg_wr_q;
    logic     dirty_q;
    logic     dirty_d;
    logic     refresh_q;
    logic     refresh_d;

    logic            accept_c;
    logic            commit_c;
    row_idx_t        lk_row;
    logic [COLS-1:0] lk_row_vec_c;
    logic            unused_c;

    // Columns at or above COLS are ignored by design.
    assign unused_c = ^bg_data;

    // A write needs an idle cycle before it; holding or hopping rows does nothing.
    assign accept_c = (bg_wr_q == row_idx_t'(IDLE_ROW)) && (bg_wr < row_idx_t'(ROWS));
    assign commit_c = frame_start && dirty_q;

    // Status next-state: a write in the same cycle as frame_start wins.
    always_comb begin
        dirty_d   = dirty_q;
        refresh_d = refresh_q;
        if (accept_c) begin
            dirty_d   = 1'b1;
            refresh_d = 1'b0;
        end else if (frame_start) begin
            dirty_d   = 1'b0;
            refresh_d = 1'b1;
        end
    end

    // Write capture and status registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bg_wr_q   <= row_idx_t'(IDLE_ROW);
            dirty_q   <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            bg_wr_q   <= bg_wr;
            dirty_q   <= dirty_d;
            refresh_q <= refresh_d;
        end
    end

    // Shadow and active bitmaps; the commit copies the pre-write shadow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int r = 0; r < int'(ROWS); r++) begin
                shadow_q[r] <= '0;
                active_q[r] <= '0;
            end
        end else begin
            if (accept_c) begin
                shadow_q[bg_wr] <= bg_data[COLS-1:0];
            end
            if (commit_c) begin
                active_q <= shadow_q;
            end
        end
    end

    // Row fetch for the lookup; rows beyond the maze read as empty.
    assign lk_row_vec_c = (lk_row < row_idx_t'(ROWS)) ? active_q[lk_row] : '0;

    maze_pixel_lookup #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .TILE_SHIFT (TILE_SHIFT),
        .X_OFFSET   (X_OFFSET),
        .Y_OFFSET   (Y_OFFSET)
    ) u_lookup (
        .clk       (clk),
        .reset_n   (reset_n),
        .pix_x_i   (pix_x),
        .pix_y_i   (pix_y),
        .pix_de_i  (pix_de),
        .row_sel_o (lk_row),
        .row_vec_i (lk_row_vec_c),
        .wall_o    (wall)
    );

    assign refresh_image = refresh_q;
    assign dirty         = dirty_q;

endmodule

// File: tb/tb_maze_bitmap_store.sv
// Directed testbench for maze_bitmap_store with hand-computed expectations.
module tb_maze_bitmap_store;

    logic        clk;
    logic        reset_n;
    logic [31:0] bg_data;
    logic [4:0]  bg_wr;
    logic        frame_start;
    logic [11:0] pix_x;
    logic [11:0] pix_y;
    logic        pix_de;
    logic        wall;
    logic        refresh_image;
    logic        dirty;

    int n_checks;
    int n_errors;

    maze_bitmap_store dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bg_data       (bg_data),
        .bg_wr         (bg_wr),
        .frame_start   (frame_start),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_de        (pix_de),
        .wall          (wall),
        .refresh_image (refresh_image),
        .dirty         (dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One accepted row write: index for one cycle, then back to idle.
    task automatic write_row(input logic [4:0] idx, input logic [31:0] data);
        bg_wr   = idx;
        bg_data = data;
        tick();
        bg_wr   = 5'd31;
        tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic lookup(input string tag, input int x, input int y, input logic de,
                          input logic exp);
        pix_x  = 12'(x);
        pix_y  = 12'(y);
        pix_de = de;
        tick();
        tick();
        check(tag, {31'd0, wall}, {31'd0, exp});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        reset_n     = 1'b0;
        bg_data     = '0;
        bg_wr       = 5'd31;
        frame_start = 1'b0;
        pix_x       = '0;
        pix_y       = '0;
        pix_de      = 1'b1;
        tick();
        tick();
        check("rst_wall", {31'd0, wall}, 32'd0);
        check("rst_refresh", {31'd0, refresh_image}, 32'd0);
        check("rst_dirty", {31'd0, dirty}, 32'd0);
        reset_n = 1'b1;
        tick();

        // Empty commit: refresh rises, nothing is a wall.
        frame();
        check("f0_refresh", {31'd0, refresh_image}, 32'd1);
        check("f0_dirty", {31'd0, dirty}, 32'd0);
        lookup("empty_origin", 208, 116, 1'b1, 1'b0);
        lookup("empty_mid", 300, 200, 1'b1, 1'b0);
        lookup("empty_last", 431, 363, 1'b1, 1'b0);

        // Row 5, column 0.
        write_row(5'd5, 32'h0000_0001);
        check("w5_dirty", {31'd0, dirty}, 32'd1);
        check("w5_refresh", {31'd0, refresh_image}, 32'd0);
        frame();
        check("c5_dirty", {31'd0, dirty}, 32'd0);
        check("c5_refresh", {31'd0, refresh_image}, 32'd1);
        lookup("r5c0", 208, 156, 1'b1, 1'b1);
        lookup("r5c1", 216, 156, 1'b1, 1'b0);
        lookup("r5c0_de0", 208, 156, 1'b0, 1'b0);

        // Hold row 5 with changing data, then hop to row 6 without idle.
        for (int i = 0; i < 10; i++) begin
            bg_wr   = 5'd5;
            bg_data = 32'h0000_0002 << i;
            tick();
        end
        bg_wr   = 5'd6;
        bg_data = 32'hFFFF_FFFF;
        tick();
        tick();
        bg_wr = 5'd31;
        tick();
        frame();
        lookup("hold_c1", 216, 156, 1'b1, 1'b1);
        lookup("hold_c2", 224, 156, 1'b1, 1'b0);
        lookup("hold_c0", 208, 156, 1'b1, 1'b0);
        lookup("hop_r6", 208, 164, 1'b1, 1'b0);

        // Write row 4, then write row 3 in the same cycle as frame_start.
        write_row(5'd4, 32'h0000_0001);
        bg_wr       = 5'd3;
        bg_data     = 32'h0000_0001;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        bg_wr       = 5'd31;
        check("sim_dirty", {31'd0, dirty}, 32'd1);
        check("sim_refresh", {31'd0, refresh_image}, 32'd0);
        lookup("sim_r4", 208, 148, 1'b1, 1'b1);
        lookup("sim_r3", 208, 140, 1'b1, 1'b0);
        frame();
        check("sim2_dirty", {31'd0, dirty}, 32'd0);
        check("sim2_refresh", {31'd0, refresh_image}, 32'd1);
        lookup("sim2_r3", 208, 140, 1'b1, 1'b1);

        // Row 0 full; check edges before and after commit.
        write_row(5'd0, 32'hFFFF_FFFF);
        lookup("r0_precommit", 208, 116, 1'b1, 1'b0);
        frame();
        lookup("r0_left", 208, 116, 1'b1, 1'b1);
        lookup("r0_right", 431, 116, 1'b1, 1'b1);
        lookup("r0_past_right", 432, 116, 1'b1, 1'b0);
        lookup("r0_before_left", 207, 116, 1'b1, 1'b0);
        lookup("r0_above", 208, 115, 1'b1, 1'b0);

        // Pending write lost on reset; committed rows cleared too.
        write_row(5'd10, 32'h0000_0001);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst2_dirty", {31'd0, dirty}, 32'd0);
        check("rst2_refresh", {31'd0, refresh_image}, 32'd0);
        check("rst2_wall", {31'd0, wall}, 32'd0);
        frame();
        check("rst2_f_dirty", {31'd0, dirty}, 32'd0);
        lookup("rst2_r0", 208, 116, 1'b1, 1'b0);
        lookup("rst2_r10", 208, 196, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
